// File: rtl/adf4159_reg_sequencer.sv
// Shadow-register command stage for the ADF4159 SPI serializer.
// Holds R0..R7 and streams them to the serializer over a load/busy handshake:
// either the full program (R7 down to R0) or only the dirty registers.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   cfg_we/addr/data    shadow register write (accepted in any state)
//   start_all           pulse: send all eight registers
//   start_dirty         pulse: send only registers with their dirty bit set
//   spi_load, spi_word  load request and word to the serializer (level)
//   spi_busy            serializer busy flag
//   busy                sequence in progress
//   done                one-cycle pulse at the end of every sequence
//   err_timeout         sticky: last sequence aborted on handshake timeout
//   dirty               per-register pending-transmit mask
module adf4159_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned GAP_CYC     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        start_all,
  input  logic        start_dirty,
  output logic        spi_load,
  output logic [31:0] spi_word,
  input  logic        spi_busy,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [7:0]  dirty
);

  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t        state;
  logic [31:0]   shadow [NREG];
  logic [7:0]    sel;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [2:0]    top_c;

  // Highest set bit; later (higher) indices overwrite lower ones.
  function automatic logic [2:0] top_bit(input logic [7:0] s);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (s[k]) r = 3'(k);
    end
    return r;
  endfunction

  always_comb top_c = top_bit(sel);

  // Sequencer FSM, shadow array and dirty tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      sel         <= 8'h00;
      idx         <= 3'd0;
      cnt         <= '0;
      spi_load    <= 1'b0;
      spi_word    <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      dirty       <= 8'hFF;
      for (int k = 0; k < int'(NREG); k++) shadow[k] <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_all || start_dirty) begin
            sel         <= start_all ? 8'hFF : dirty;
            busy        <= start_all || (dirty != 8'h00);
            err_timeout <= 1'b0;
            state       <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (sel == 8'h00) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            // Word is frozen here; later writes to this register wait for the next push.
            idx        <= top_c;
            spi_word   <= {shadow[top_c][31:3], top_c};
            sel[top_c] <= 1'b0;
            spi_load   <= 1'b1;
            cnt        <= CW'(1);
            state      <= S_LOAD;
          end
        end
        S_LOAD, S_WAIT_ACK: begin
          // cnt = cycles spi_load has been high including this one.
          if (state == S_LOAD) dirty[idx] <= 1'b0;
          if (spi_busy) begin
            spi_load <= 1'b0;
            state    <= S_WAIT_DONE;
          end else if (cnt >= CW'(TIMEOUT_CYC)) begin
            spi_load    <= 1'b0;
            err_timeout <= 1'b1;
            dirty[idx]  <= 1'b1;
            sel         <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_FINISH;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= S_WAIT_ACK;
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            cnt   <= CW'(1);
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt >= CW'(GAP_CYC)) state <= S_SELECT;
          else                     cnt   <= cnt + CW'(1);
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      // A host write always wins over the LOAD-time dirty clear.
      if (cfg_we) begin
        shadow[cfg_addr] <= cfg_data;
        dirty[cfg_addr]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adf4159_reg_sequencer.sv
// Self-checking bench for adf4159_reg_sequencer: randomized serializer timing
// and register contents against a register-level reference model.
module tb_adf4159_reg_sequencer;

  localparam int unsigned TO = 16;
  localparam int unsigned GP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_data = 32'd0;
  logic        start_all = 1'b0;
  logic        start_dirty = 1'b0;
  logic        spi_busy = 1'b0;
  logic        spi_load;
  logic [31:0] spi_word;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [7:0]  dirty;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: register contents, pending mask, expected send order.
  logic [31:0] mdl [8];
  logic [7:0]  mdirty = 8'hFF;
  int          exp_q[$];
  bit          noack = 1'b0;
  int          acked = 0;
  int          done_cnt = 0;
  int          hi_run = 0;

  adf4159_reg_sequencer #(.TIMEOUT_CYC(TO), .GAP_CYC(GP)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start_all(start_all), .start_dirty(start_dirty), .spi_load(spi_load),
    .spi_word(spi_word), .spi_busy(spi_busy), .busy(busy), .done(done),
    .err_timeout(err_timeout), .dirty(dirty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (spi_load) hi_run++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] wexp(input int i);
    logic [2:0] ix;
    ix = 3'(i);
    return {mdl[i][31:3], ix};
  endfunction

  // Serializer model with random acknowledge latency and busy length.
  initial begin : ser
    int fall_cyc;
    bit have_fall;
    int d;
    int h;
    int e;
    int g;
    have_fall = 1'b0;
    fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst && spi_load && !spi_busy) begin
        if (have_fall) begin
          g = cyc - fall_cyc;
          chk("gap_min", 32'(g >= int'(GP) + 1), 32'd1);
        end
        if (exp_q.size() == 0) begin
          e = -1;
          chk("unexpected_load", spi_word, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word", spi_word, wexp(e));
        end
        if (noack) begin
          for (int k = 0; k < 64 && spi_load; k++) @(negedge clk);
          have_fall = 1'b0;
        end else begin
          d = $urandom_range(0, 3);
          h = $urandom_range(1, 6);
          repeat (d) @(negedge clk);
          spi_busy = 1'b1;
          acked++;
          if (e >= 0) mdirty[e] = 1'b0;
          repeat (h) @(negedge clk);
          spi_busy = 1'b0;
          fall_cyc = cyc;
          have_fall = 1'b1;
        end
      end
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = d;
    mdl[a] = d;
    mdirty[a] = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    mdirty = 8'hFF;
  endtask

  // Pulse start and build the expected descending send order.
  task automatic start(input bit a, input bit dd);
    logic [7:0] s;
    s = a ? 8'hFF : mdirty;
    exp_q.delete();
    for (int i = 7; i >= 0; i--) if (s[i]) exp_q.push_back(i);
    done_cnt = 0;
    @(negedge clk);
    start_all = a;
    start_dirty = dd;
    @(negedge clk);
    start_all = 1'b0;
    start_dirty = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_all_sent"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_dirty"}, 32'(dirty), 32'(mdirty));
  endtask

  task automatic wait_acked(input int target);
    int n;
    n = 0;
    while (acked < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ack_reached", 32'(acked >= target), 32'd1);
  endtask

  initial begin : main
    int a0;
    int n;
    bit ra;
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_spi_load", 32'(spi_load), 32'd0);
    chk("rst_spi_word", spi_word, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'h0000_00FF);

    // Full program from all-zero shadow: words 7..0
    start(1'b1, 1'b0);
    wait_done("all_zero");
    chk("all_zero_dirty_clear", 32'(dirty), 32'd0);

    // Two dirty registers only
    wr(2, 32'hDEAD_BEEF);
    wr(5, 32'h1234_5678);
    start(1'b0, 1'b1);
    wait_done("two_dirty");

    // Empty dirty sequence
    hi_run = 0;
    start(1'b0, 1'b1);
    chk("empty_busy_c1", 32'(busy), 32'd0);
    chk("empty_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    chk("empty_busy_c2", 32'(busy), 32'd0);
    chk("empty_done_c2", 32'(done), 32'd1);
    @(negedge clk);
    chk("empty_done_c3", 32'(done), 32'd0);
    chk("empty_done_cnt", 32'(done_cnt), 32'd1);
    chk("empty_no_load", 32'(hi_run), 32'd0);

    // Handshake timeout on the first word
    do_reset();
    noack = 1'b1;
    hi_run = 0;
    start(1'b1, 1'b0);
    while (exp_q.size() > 1) exp_q.pop_back();
    wait_done("timeout");
    chk("timeout_load_len", 32'(hi_run), 32'(TO));
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_dirty_ff", 32'(dirty), 32'h0000_00FF);
    noack = 1'b0;
    start(1'b0, 1'b1);
    chk("err_cleared", 32'(err_timeout), 32'd0);
    wait_done("after_timeout");

    // Writes during a sequence
    for (int i = 0; i < 8; i++) wr(i, $urandom);
    a0 = acked;
    start(1'b1, 1'b0);
    wait_acked(a0 + 2);
    wr(6, $urandom);
    wait_acked(a0 + 3);
    wr(3, $urandom);
    wait_done("mid_write");
    chk("dirty6_kept", 32'(dirty[6]), 32'd1);

    // Both starts together: start_all wins
    start(1'b0, 1'b1);
    wait_done("flush6");
    wr(0, $urandom);
    chk("dirty_only0", 32'(dirty), 32'h0000_0001);
    start(1'b1, 1'b1);
    wait_done("both_starts");

    // Random register updates and start modes
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wr(int'($urandom_range(0, 7)), $urandom);
      ra = 1'($urandom_range(0, 1));
      start(ra, ra ? 1'($urandom_range(0, 1)) : 1'b1);
      wait_done("random");
    end

    // Asynchronous reset mid-word
    start(1'b1, 1'b0);
    n = 0;
    while (!spi_load && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_load_seen", 32'(spi_load), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_spi_load", 32'(spi_load), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dirty", 32'(dirty), 32'h0000_00FF);
    chk("midrst_err", 32'(err_timeout), 32'd0);
    repeat (20) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
